// File: rtl/lc3_mio_ctrl.sv
// lc3_mio_ctrl: LC-3 memory/I-O controller with RAM timing and keyboard/display registers
module lc3_mio_ctrl #(
    parameter int MEM_LAT  = 2,
    parameter int DSP_BUSY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_out,
    input  logic [15:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] mio_rdata,
    output logic        ready,
    input  logic        LD_char,
    input  logic [7:0]  I_char,
    output logic [15:0] DDR,
    output logic        WR_DDR
);
    typedef enum logic [1:0] {IDLE, MEM, DEV, DONE} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [7:0]  busy;
    logic        w_l;
    logic        kbsr;
    logic [7:0]  kbdr;
    logic        dsr;
    logic [15:0] dev_rdata;
    // device register read mux, addressed by the latched access address
    always_comb begin
        dev_rdata = (mem_addr == 16'hFE00) ? {kbsr, 15'b0} :
                    (mem_addr == 16'hFE02) ? {8'h00, kbdr} :
                    (mem_addr == 16'hFE04) ? {dsr, 15'b0} :
                    (mem_addr == 16'hFE06) ? DDR : 16'h0000;
    end
    // access FSM plus keyboard and display register state; DDR writes act on the accept edge so WR_DDR lands in the DEV cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            busy      <= 8'd0;
            w_l       <= 1'b0;
            kbsr      <= 1'b0;
            kbdr      <= 8'h00;
            dsr       <= 1'b1;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            mio_rdata <= 16'h0000;
            ready     <= 1'b0;
            DDR       <= 16'h0000;
            WR_DDR    <= 1'b0;
        end else begin
            ready  <= 1'b0;
            WR_DDR <= 1'b0;
            if (busy != 8'd0) busy <= busy - 8'd1;
            if (busy == 8'd1) dsr <= 1'b1;
            case (state)
                IDLE: if (mio_en) begin
                    mem_addr  <= mar;
                    mem_wdata <= mdr_out;
                    w_l       <= r_w;
                    cnt       <= 4'(MEM_LAT);
                    if (mar >= 16'hFE00) begin
                        state <= DEV;
                        if (r_w && mar == 16'hFE06 && dsr) begin
                            DDR    <= mdr_out;
                            WR_DDR <= 1'b1;
                            dsr    <= 1'b0;
                            busy   <= 8'(DSP_BUSY);
                        end
                    end else begin
                        state  <= MEM;
                        mem_en <= 1'b1;
                        mem_we <= r_w;
                    end
                end
                MEM: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        ready  <= 1'b1;
                        state  <= DONE;
                        if (!w_l) mio_rdata <= mem_rdata;
                    end
                end
                DEV: begin
                    ready <= 1'b1;
                    state <= DONE;
                    if (!w_l) begin
                        mio_rdata <= dev_rdata;
                        if (mem_addr == 16'hFE02) kbsr <= 1'b0;
                    end
                end
                DONE: state <= IDLE;
            endcase
            if (LD_char) begin
                kbdr <= I_char;
                kbsr <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lc3_mio_ctrl.sv
// tb_lc3_mio_ctrl: directed plus randomized accesses checked against a behavioural model
module tb_lc3_mio_ctrl;
    localparam int MEM_LAT  = 2;
    localparam int DSP_BUSY = 4;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mio_en = 1'b0;
    logic        r_w = 1'b0;
    logic [15:0] mar = 16'h0;
    logic [15:0] mdr_out = 16'h0;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_en, mem_we, ready, WR_DDR;
    logic [15:0] mem_addr, mem_wdata, mio_rdata, DDR;
    logic        LD_char = 1'b0;
    logic [7:0]  I_char = 8'h0;
    int total = 0;
    int passed = 0;
    int cyc = 0;
    logic [15:0] ram [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    bit          kb_full = 1'b0;
    logic [7:0]  kb_char = 8'h0;
    logic [15:0] ddr_m = 16'h0;
    int          ready_at = 0;
    logic [15:0] last_rd = 16'h0;

    lc3_mio_ctrl #(.MEM_LAT(MEM_LAT), .DSP_BUSY(DSP_BUSY)) dut (
        .clk(clk), .reset(reset), .mio_en(mio_en), .r_w(r_w), .mar(mar), .mdr_out(mdr_out),
        .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mio_rdata(mio_rdata), .ready(ready), .LD_char(LD_char),
        .I_char(I_char), .DDR(DDR), .WR_DDR(WR_DDR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
    always @(negedge clk) mem_rdata = ram.exists(mem_addr) ? ram[mem_addr] : 16'h0;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic kb(input logic [7:0] ch);
        LD_char = 1'b1;
        I_char  = ch;
        @(posedge clk);
        #1;
        LD_char = 1'b0;
        kb_full = 1'b1;
        kb_char = ch;
    endtask

    task automatic model_reset();
        kb_full  = 1'b0;
        kb_char  = 8'h0;
        ddr_m    = 16'h0;
        ready_at = 0;
        last_rd  = 16'h0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'h0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'h0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        chk({tag, "_wr_ddr"}, 32'(WR_DDR), 32'h0);
        chk({tag, "_ddr"}, 32'(DDR), 32'h0);
        chk({tag, "_mio_rdata"}, 32'(mio_rdata), 32'h0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    endtask

    // one CPU access from an IDLE cycle through the ready pulse; ld raises LD_char on the DEV edge
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input bit ld, input logic [7:0] ch);
        int k, n, men, wr;
        bit got, io, exp_wr;
        logic [15:0] exp_rd;
        io = (a >= 16'hFE00);
        mio_en = 1'b1; r_w = w; mar = a; mdr_out = d;
        @(posedge clk);
        #1;
        k = cyc;
        mar = 16'($urandom);
        mdr_out = 16'($urandom);
        if (ld) begin
            LD_char = 1'b1;
            I_char  = ch;
        end
        exp_wr = 1'b0;
        if (io && w && a == 16'hFE06 && k >= ready_at) begin
            exp_wr   = 1'b1;
            ddr_m    = d;
            ready_at = k + DSP_BUSY + 1;
        end
        exp_rd = last_rd;
        if (!w) begin
            if (!io) exp_rd = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
            else exp_rd = (a == 16'hFE00) ? {kb_full, 15'b0} :
                          (a == 16'hFE02) ? {8'h00, kb_char} :
                          (a == 16'hFE04) ? {(k + 1 >= ready_at), 15'b0} :
                          (a == 16'hFE06) ? ddr_m : 16'h0;
            last_rd = exp_rd;
        end
        if (!io && w) ref_mem[a] = d;
        if (ld) begin
            kb_full = 1'b1;
            kb_char = ch;
        end else if (io && !w && a == 16'hFE02) kb_full = 1'b0;
        men = 0; wr = 0; got = 1'b0;
        for (n = 1; n <= 40; n++) begin
            if (mem_en) begin
                men++;
                chk("mem_en_window", 32'(n <= MEM_LAT), 32'h1);
                chk("mem_addr", 32'(mem_addr), 32'(a));
                chk("mem_we", 32'(mem_we), 32'(w));
                if (w) chk("mem_wdata", 32'(mem_wdata), 32'(d));
            end
            if (WR_DDR) begin
                wr++;
                chk("wr_ddr_cycle", 32'(n), 32'h1);
                chk("ddr_at_wr", 32'(DDR), 32'(d));
            end
            if (ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            LD_char = 1'b0;
        end
        chk("ready_seen", 32'(got), 32'h1);
        chk("ready_cycle", 32'(n), io ? 32'd2 : 32'(MEM_LAT + 1));
        chk("mem_en_cycles", 32'(men), io ? 32'd0 : 32'(MEM_LAT));
        chk("wr_ddr_pulses", 32'(wr), 32'(exp_wr));
        chk("mio_rdata", 32'(mio_rdata), 32'(exp_rd));
        chk("ddr", 32'(DDR), 32'(ddr_m));
        mio_en = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_one_cycle", 32'(ready), 32'h0);
    endtask

    initial begin
        int rdy;
        logic [15:0] a;
        idle(3);
        chk_reset_outputs("reset");
        reset = 1'b1;
        idle(2);
        chk_reset_outputs("idle");
        access(1'b0, 16'hFE04, 16'h0, 1'b0, 8'h0);
        access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0);
        ram[16'h3000] = 16'h1234;
        ref_mem[16'h3000] = 16'h1234;
        access(1'b0, 16'h3000, 16'h0, 1'b0, 8'h0);
        access(1'b1, 16'h3001, 16'hABCD, 1'b0, 8'h0);
        access(1'b0, 16'h3001, 16'h0, 1'b0, 8'h0);
        kb(8'h30);
        access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0);
        access(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h0);
        access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0);
        kb(8'h30);
        kb(8'h31);
        access(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h0);
        kb(8'h40);
        access(1'b0, 16'hFE02, 16'h0, 1'b1, 8'h41);
        access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0);
        access(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h0);
        access(1'b1, 16'hFE06, 16'h0041, 1'b0, 8'h0);
        access(1'b1, 16'hFE06, 16'h0042, 1'b0, 8'h0);
        for (int p = 0; p < 4; p++) access(1'b0, 16'hFE04, 16'h0, 1'b0, 8'h0);
        for (int g = 0; g < 4; g++) begin
            idle(DSP_BUSY + 2);
            access(1'b1, 16'hFE06, 16'h0050 + 16'(g), 1'b0, 8'h0);
            idle(g);
            access(1'b0, 16'hFE04, 16'h0, 1'b0, 8'h0);
            idle(DSP_BUSY + 2);
            access(1'b1, 16'hFE06, 16'h0060 + 16'(g), 1'b0, 8'h0);
            idle(g);
            access(1'b1, 16'hFE06, 16'h0070 + 16'(g), 1'b0, 8'h0);
        end
        access(1'b1, 16'hFE00, 16'hFFFF, 1'b0, 8'h0);
        access(1'b1, 16'hFE02, 16'h1111, 1'b0, 8'h0);
        access(1'b1, 16'hFE04, 16'h2222, 1'b0, 8'h0);
        access(1'b0, 16'hFE10, 16'h0, 1'b0, 8'h0);
        access(1'b1, 16'hFE10, 16'h3333, 1'b0, 8'h0);
        kb(8'h55);
        idle(DSP_BUSY + 2);
        access(1'b1, 16'hFE06, 16'h0077, 1'b0, 8'h0);
        mio_en = 1'b1; r_w = 1'b0; mar = 16'h3000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_mem_en", 32'(mem_en), 32'h1);
        reset = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        mio_en = 1'b0;
        model_reset();
        idle(2);
        reset = 1'b1;
        rdy = 0;
        for (int c = 0; c < 6; c++) begin
            if (ready) rdy++;
            idle(1);
        end
        chk("no_ready_after_abort", 32'(rdy), 32'h0);
        access(1'b0, 16'hFE04, 16'h0, 1'b0, 8'h0);
        access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h0);
        access(1'b0, 16'h3000, 16'h0, 1'b0, 8'h0);
        access(1'b0, 16'hFE10, 16'h0, 1'b0, 8'h0);
        for (int i = 0; i < 120; i++) begin
            idle($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0, 1: access(1'b1, 16'h3000 + 16'($urandom_range(0, 7)), 16'($urandom), 1'b0, 8'h0);
                2:    access(1'b0, 16'h3000 + 16'($urandom_range(0, 7)), 16'h0, 1'b0, 8'h0);
                3:    access(1'b0, 16'($urandom_range(0, 32'hFDFF)), 16'h0, 1'b0, 8'h0);
                4:    kb(8'($urandom));
                5: begin
                    a = 16'hFE00 + 16'(2 * $urandom_range(0, 3));
                    access(1'b0, a, 16'h0, 1'b0, 8'h0);
                end
                6:    access(1'b1, 16'hFE06, 16'($urandom), 1'b0, 8'h0);
                7:    access(1'b0, 16'hFE02, 16'h0, 1'b1, 8'($urandom));
                8: begin
                    a = 16'($urandom_range(32'hFE07, 32'hFFFF));
                    access(1'($urandom), a, 16'($urandom), 1'b0, 8'h0);
                end
                default: begin
                    a = 16'hFE00 + 16'(2 * $urandom_range(0, 2));
                    access(1'b1, a, 16'($urandom), 1'b0, 8'h0);
                end
            endcase
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
